// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: execute-stage request/response bundle for the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    modport master (output start, op, op_a, op_b, mthi, mtlo, mt_data, input hi, lo, busy, done);
    modport slave  (input start, op, op_a, op_b, mthi, mtlo, mt_data, output hi, lo, busy, done);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with MTHI/MTLO writes.
module hilo_muldiv_unit #(
    parameter int ITERS = 32
) (
    input logic           clk,
    input logic           reset,
    hilo_muldiv_if.slave  bus
);
    localparam logic [4:0] LAST = 5'(ITERS - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;

    logic        is_div, neg_q, neg_r, done_q;
    logic [4:0]  count;
    logic [31:0] a_mag, b_mag, raw_a, rem, quot, hi_q, lo_q;
    logic [63:0] prod;
    logic        sgn, div_ge;
    logic [31:0] am, bm, rem_nx;
    logic [32:0] mul_sum, div_sh;
    logic [63:0] prod_fix;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state == IDLE ? (bus.start ? CALC : IDLE) :
                   state == CALC ? (count == LAST ? FIX : CALC) : IDLE;
    end

    always_comb begin
        bus.busy = state != IDLE;
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
    end

    // Magnitudes are taken once at issue so the loop itself is purely unsigned.
    always_comb begin
        sgn      = !bus.op[0];
        am       = sgn && bus.op_a[31] ? -bus.op_a : bus.op_a;
        bm       = sgn && bus.op_b[31] ? -bus.op_b : bus.op_b;
        mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);
        div_sh   = {rem, quot[31]};
        div_ge   = div_sh >= {1'b0, b_mag};
        rem_nx   = div_ge ? 32'(div_sh - {1'b0, b_mag}) : div_sh[31:0];
        prod_fix = neg_q ? -prod : prod;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_q <= 1'b0;
            count  <= '0;
            a_mag  <= '0;
            b_mag  <= '0;
            raw_a  <= '0;
            rem    <= '0;
            quot   <= '0;
            prod   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= state == FIX;
            if (state == IDLE) begin
                if (bus.start) begin
                    is_div <= bus.op[1];
                    neg_q  <= sgn & (bus.op_a[31] ^ bus.op_b[31]);
                    neg_r  <= sgn & bus.op_a[31];
                    a_mag  <= am;
                    b_mag  <= bm;
                    raw_a  <= bus.op_a;
                    count  <= '0;
                    prod   <= {32'd0, bm};
                    rem    <= '0;
                    quot   <= am;
                end else begin
                    if (bus.mthi) hi_q <= bus.mt_data;
                    if (bus.mtlo) lo_q <= bus.mt_data;
                end
            end else if (state == CALC) begin
                count <= count + 5'd1;
                if (is_div) begin
                    rem  <= rem_nx;
                    quot <= {quot[30:0], div_ge};
                end else begin
                    prod <= {mul_sum, prod[31:1]};
                end
            end else if (is_div) begin
                // Divide by zero returns all-ones quotient and the untouched dividend.
                if (b_mag == '0) begin
                    hi_q <= raw_a;
                    lo_q <= 32'hFFFF_FFFF;
                end else begin
                    hi_q <= neg_r ? -rem : rem;
                    lo_q <= neg_q ? -quot : quot;
                end
            end else begin
                {hi_q, lo_q} <= prod_fix;
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed vectors for the HI/LO multiply/divide unit.
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   n;

    hilo_muldiv_if bus();
    hilo_muldiv_unit #(.ITERS(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op_a  = a;
        bus.op_b  = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!bus.done && cyc < 40);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int c;
        launch(o, a, b);
        wait_done(c);
        check({tag, "_cycles"}, 32'(c), 32'd33);
        check({tag, "_hi"}, bus.hi, eh);
        check({tag, "_lo"}, bus.lo, el);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.op_a = '0; bus.op_b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_e0", 32'(bus.busy), 32'd1);
        check("multu_hold_hi", bus.hi, 32'd0);
        wait_done(n);
        check("multu_cycles", 32'(n), 32'd33);
        check("multu_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus.lo, 32'h0000_0001);
        check("multu_busy_end", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("multu_done_once", 32'(bus.done), 32'd0);

        run("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run("div_nn",    2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu",      2'b11, 32'd7,         32'd2,        32'd1,         32'd3);
        run("div_pn",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
        run("divu_zero", 2'b11, 32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF);
        run("div_zero",  2'b10, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);

        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mt_both_hi", bus.hi, 32'h1357_9BDF);
        check("mt_both_lo", bus.lo, 32'h1357_9BDF);

        launch(2'b01, 32'h0001_0000, 32'h0001_0000);
        repeat (3) @(posedge clk);
        #1;
        bus.mthi = 1'b1; bus.mt_data = 32'h0000_AAAA;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        check("mthi_busy_hi", bus.hi, 32'h1357_9BDF);
        wait_done(n);
        check("mthi_busy_res_hi", bus.hi, 32'd1);
        check("mthi_busy_res_lo", bus.lo, 32'd0);

        launch(2'b11, 32'd7, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd3; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(n);
        check("restart_done", 32'(bus.done), 32'd1);
        check("restart_hi", bus.hi, 32'd1);
        check("restart_lo", bus.lo, 32'd3);
        @(posedge clk); #1;
        check("restart_idle", 32'(bus.busy), 32'd0);

        bus.mtlo = 1'b1; bus.mt_data = 32'h5555;
        launch(2'b11, 32'd7, 32'd2);
        bus.mtlo = 1'b0;
        wait_done(n);
        check("start_mtlo_lo", bus.lo, 32'd3);
        check("start_mtlo_hi", bus.hi, 32'd1);

        launch(2'b01, 32'd5, 32'd6);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        check("midrst_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run("multu_5x6", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
